// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM encoding and serial line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  localparam logic LineIdle = 1'b1;
  localparam logic StartBit = 1'b0;
  localparam logic StopBit  = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit timer: pulses bit_tick on the last clk cycle of every CLK_DIV-cycle bit period.
module uart_baud_gen #(
  parameter int unsigned CLK_DIV = 217
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    bit_tick = (cnt_q == CntMax);
    cnt_d    = (clear || bit_tick) ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an inline transmit FIFO, optional parity and one or two stop bits.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 217,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  input  logic                          two_stop,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_BITS - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q, count_d;
  logic                 ready_q;
  logic                 push, pop, full, empty;
  logic [DATA_BITS-1:0] head;

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 parity_q, parity_d;
  logic                 par_en_q, par_en_d;
  logic                 two_stop_q, two_stop_d;
  logic                 txd_q, txd_d;
  logic                 bit_tick;

  // ready_q keeps tx_ready low until the first edge after reset
  assign full       = (count_q == FullCnt);
  assign empty      = (count_q == '0);
  assign tx_ready   = ready_q & ~full;
  assign push       = tx_valid & tx_ready;
  assign head       = mem_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign txd        = txd_q;
  assign busy       = (state_q != StIdle);

  always_comb begin
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
      ready_q <= 1'b1;
    end
  end

  uart_baud_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_gen (
    .clk      (clk),
    .rst      (rst),
    .clear    (pop),
    .bit_tick (bit_tick)
  );

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    parity_d   = parity_q;
    par_en_d   = par_en_q;
    two_stop_d = two_stop_q;
    txd_d      = txd_q;
    pop        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!empty) pop = 1'b1;
      end
      StStart: begin
        if (bit_tick) begin
          state_d = StData;
          txd_d   = shreg_q[0];
        end
      end
      StData: begin
        if (bit_tick) begin
          if (bit_idx_q == LastIdx) begin
            state_d = par_en_q ? StParity : StStop;
            txd_d   = par_en_q ? parity_q : StopBit;
          end else begin
            bit_idx_d = bit_idx_q + IdxW'(1);
            shreg_d   = shreg_q >> 1;
            txd_d     = shreg_q[1];
          end
        end
      end
      StParity: begin
        if (bit_tick) begin
          state_d = StStop;
          txd_d   = StopBit;
        end
      end
      StStop: begin
        if (bit_tick) begin
          if (two_stop_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else if (!empty) begin
            pop = 1'b1;
          end else begin
            state_d = StIdle;
            txd_d   = LineIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        txd_d   = LineIdle;
      end
    endcase

    // Frame options are captured together with the word so later changes only hit later frames
    if (pop) begin
      state_d    = StStart;
      txd_d      = StartBit;
      shreg_d    = head;
      bit_idx_d  = '0;
      stop_idx_d = 1'b0;
      parity_d   = (^head) ^ parity_odd;
      par_en_d   = parity_en;
      two_stop_d = two_stop;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      parity_q   <= 1'b0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
      txd_q      <= LineIdle;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      parity_q   <= parity_d;
      par_en_q   <= par_en_d;
      two_stop_q <= two_stop_d;
      txd_q      <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected frames, a line monitor decodes txd.
module tb_uart_tx_fifo;

  localparam int unsigned ClkDiv   = 4;
  localparam int unsigned DataBits = 8;
  localparam int unsigned Depth    = 4;

  logic       clk, rst;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic       parity_en, parity_odd, two_stop;
  logic       txd, busy;
  logic [2:0] fifo_count;

  typedef struct {
    logic [11:0] bits;
    int          nbits;
    bit          last;
    logic [7:0]  data;
  } frame_t;

  frame_t exp_q[$];
  int     checks = 0;
  int     errors = 0;

  uart_tx_fifo #(
    .CLK_DIV    (ClkDiv),
    .DATA_BITS  (DataBits),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .two_stop   (two_stop),
    .txd        (txd),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  // par is the hand-computed parity bit for d; ignored when pen=0
  function automatic frame_t make_frame(input logic [7:0] d, input bit pen, input bit par,
                                        input bit ts, input bit last);
    frame_t f;
    int     n;
    f.bits = '1;
    f.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) f.bits[1+i] = d[i];
    n = 9;
    if (pen) begin
      f.bits[n] = par;
      n++;
    end
    f.bits[n] = 1'b1;
    n++;
    if (ts) begin
      f.bits[n] = 1'b1;
      n++;
    end
    f.nbits = n;
    f.last  = last;
    f.data  = d;
    return f;
  endfunction

  // Called and returns on a falling edge
  task automatic push(input logic [7:0] d, input bit par, input bit last);
    int n = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (tx_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL push_wait: tx_ready got %b, expected 1 within 200 cycles", tx_ready);
    end
    exp_q.push_back(make_frame(d, parity_en, par, two_stop, last));
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic busy_len(input string name, input int want, input bit poke);
    int n = 0;
    int m = 0;
    while (busy !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (poke) begin
      parity_en = 1'b1;
      two_stop  = 1'b1;
    end
    while (busy === 1'b1 && m < 200) begin
      m++;
      @(negedge clk);
    end
    if (poke) begin
      parity_en = 1'b0;
      two_stop  = 1'b0;
    end
    check(name, 32'(m), 32'(want));
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy !== 1'b0 || fifo_count !== 3'd0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Line monitor: decodes every frame on txd and compares with the queued expectation
  initial begin
    frame_t cur;
    int     idx = 0;
    int     bad = 0;
    int     busy_bad = 0;
    bit     in_frame = 1'b0;
    bit     post = 1'b0;
    bit     post_last = 1'b0;
    bit     stray = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        in_frame = 1'b0;
        post     = 1'b0;
        stray    = 1'b0;
      end else begin
        if (post) begin
          post = 1'b0;
          checks++;
          if (post_last && (txd !== 1'b1 || busy !== 1'b0)) begin
            errors++;
            $display("FAIL frame_end: txd=%b busy=%b, expected txd=1 busy=0", txd, busy);
          end else if (!post_last && txd !== 1'b0) begin
            errors++;
            $display("FAIL frame_gap: txd=%b after stop, expected next start bit 0", txd);
          end
        end
        if (stray && txd === 1'b1 && busy === 1'b0) stray = 1'b0;
        if (!in_frame && !stray && txd === 1'b0) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            stray = 1'b1;
            $display("FAIL unexpected_frame: got start bit, expected idle line");
          end else begin
            cur      = exp_q.pop_front();
            in_frame = 1'b1;
            idx      = 0;
            bad      = 0;
            busy_bad = 0;
          end
        end
        if (in_frame) begin
          if (txd !== cur.bits[idx/ClkDiv]) bad++;
          if (busy !== 1'b1) busy_bad++;
          idx++;
          if (idx == cur.nbits * ClkDiv) begin
            checks += 2;
            if (bad != 0) begin
              errors++;
              $display("FAIL frame_bits 0x%0h: %0d cycles wrong, expected pattern %b (LSB=first)",
                       cur.data, bad, cur.bits);
            end
            if (busy_bad != 0) begin
              errors++;
              $display("FAIL frame_busy 0x%0h: busy low %0d cycles, expected 0", cur.data,
                       busy_bad);
            end
            in_frame  = 1'b0;
            post      = 1'b1;
            post_last = cur.last;
          end
        end
      end
    end
  end

  initial begin
    int bad;
    rst        = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    two_stop   = 1'b0;

    // Asynchronous reset, before any clock edge
    #2 rst = 1'b1;
    #1;
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, tx_ready}, 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'd0, tx_ready}, 32'd1);

    // 0xA5, no parity, one stop: 40 cycles; mid-frame option change must not leak in
    push(8'hA5, 1'b0, 1'b1);
    busy_len("len_a5_plain", 40, 1'b1);
    wait_idle("idle_a5_plain");

    // 0xA5 with parity: even -> 0, odd -> 1, 44 cycles each
    parity_en  = 1'b1;
    parity_odd = 1'b0;
    push(8'hA5, 1'b0, 1'b1);
    busy_len("len_a5_even", 44, 1'b0);
    wait_idle("idle_a5_even");
    parity_odd = 1'b1;
    push(8'hA5, 1'b1, 1'b1);
    busy_len("len_a5_odd", 44, 1'b0);
    wait_idle("idle_a5_odd");
    parity_en  = 1'b0;
    parity_odd = 1'b0;

    // Fill the FIFO: back-to-back frames, full blocks pushes until the next pop
    push(8'h11, 1'b0, 1'b0);
    push(8'h22, 1'b0, 1'b0);
    push(8'h33, 1'b0, 1'b0);
    push(8'h44, 1'b0, 1'b0);
    push(8'h55, 1'b0, 1'b0);
    check("full_count", 32'(fifo_count), 32'd4);
    check("full_ready", {31'd0, tx_ready}, 32'd0);
    tx_data  = 8'h99;
    tx_valid = 1'b1;
    repeat (5) @(negedge clk);
    check("full_ignore", 32'(fifo_count), 32'd4);
    push(8'h66, 1'b0, 1'b1);
    check("refill_count", 32'(fifo_count), 32'd4);
    wait_idle("idle_burst");

    // Push coinciding with the STOP->START pop keeps the count at 1
    push(8'h81, 1'b0, 1'b0);
    push(8'h42, 1'b0, 1'b0);
    check("overlap_busy", {31'd0, busy}, 32'd1);
    repeat (39) @(negedge clk);
    check("overlap_count_before", 32'(fifo_count), 32'd1);
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    exp_q.push_back(make_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1));
    @(negedge clk);
    tx_valid = 1'b0;
    check("overlap_count_after", 32'(fifo_count), 32'd1);
    check("overlap_start", {31'd0, txd}, 32'd0);
    wait_idle("idle_overlap");

    // Two stop bits with 0x00: 36 cycles low then 8 high, next frame follows directly
    two_stop = 1'b1;
    push(8'h00, 1'b0, 1'b0);
    push(8'h00, 1'b0, 1'b1);
    wait_idle("idle_two_stop");
    two_stop = 1'b0;

    // Reset at cycle 15 of a frame, with one word still queued
    push(8'hC3, 1'b0, 1'b0);
    push(8'h5A, 1'b0, 1'b0);
    repeat (14) @(negedge clk);
    check("pre_rst_count", 32'(fifo_count), 32'd1);
    check("pre_rst_txd", {31'd0, txd}, 32'd0);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_txd", {31'd0, txd}, 32'd1);
    check("mid_rst_count", 32'(fifo_count), 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("no_residual_frame", 32'(bad), 32'd0);
    check("post_rst_count", 32'(fifo_count), 32'd0);
    check("post_rst_ready", {31'd0, tx_ready}, 32'd1);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLK_DIV, default 217: clk cycles per bit (≥2), giving 9600 bps at the system clock.
REQ-002 SHALL have parameter DATA_BITS, default 8: data bits per frame, legal 5..9.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: transmit FIFO entries, power of two, ≥2.
REQ-004 SHALL have port clk, input, 1: the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port tx_data, input, DATA_BITS: the word to enqueue.
REQ-007 SHALL have port tx_valid, input, 1: tx_data is valid this cycle.
REQ-008 SHALL have port tx_ready, output, 1: the FIFO can accept a word.
REQ-009 SHALL have port parity_en, input, 1: append a parity bit.
REQ-010 SHALL have port parity_odd, input, 1: 1 = odd parity, 0 = even parity.
REQ-011 SHALL have port two_stop, input, 1: 1 = two stop bits, 0 = one stop bit.
REQ-012 SHALL have port txd, output, 1: serial line, idle high.
REQ-013 SHALL have port busy, output, 1: a frame is in progress.
REQ-014 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

Function
REQ-015 SHALL enqueue tx_data on any cycle where tx_valid & tx_ready; tx_ready SHALL equal !full and is independent of a same-cycle pop.
REQ-016 SHALL ignore tx_valid while full; data is neither stored nor overwritten.
REQ-017 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, with IDLE→START when the FIFO is non-empty, START→DATA, DATA→PARITY|STOP after DATA_BITS bits, PARITY→STOP, STOP→START if the FIFO is non-empty else IDLE.
REQ-018 SHALL pop the FIFO head on the IDLE→START and STOP→START transitions; txd SHALL go low on the clock edge after the pop.
REQ-019 SHALL latch parity_en, parity_odd and two_stop at each pop; a mid-frame change SHALL affect only later frames.
REQ-020 SHALL hold every bit (start, data, parity, stop) for exactly CLK_DIV clk cycles, timed by a bit counter that is cleared at each frame start.
REQ-021 SHALL send data LSB first.
REQ-022 SHALL compute parity as the XOR of the DATA_BITS latched data bits, inverted when parity_odd=1.
REQ-023 SHALL drive stop bits high, one or two bits per the latched two_stop value.
REQ-024 SHALL send back-to-back frames with zero idle gap: the next start bit immediately follows the last stop bit.
REQ-025 SHALL assert busy from the pop through the end of the last stop bit, and deassert it only in IDLE.
REQ-026 SHALL update fifo_count on push-only (+1) and pop-only (−1), and leave it unchanged on a simultaneous push and pop.
REQ-027 SHALL keep txd glitch-free by driving it from a register.

Reset
REQ-028 SHALL, while rst=1, asynchronously force txd=1, busy=0, tx_ready=0, fifo_count=0, FSM=IDLE, all counters=0 and FIFO pointers=0.
REQ-029 SHALL drive tx_ready=1 on the first clk edge after rst is released.
REQ-030 SHALL, on reset mid-frame, abort the frame, drive txd high immediately and discard all FIFO contents.

Structure
REQ-031 SHALL place the FSM state encoding and the bit-phase constants in the shared package uart_pkg.
REQ-032 SHALL instantiate one sub-module, uart_baud_gen (parameter CLK_DIV; inputs clk, rst, clear; output bit_tick), as the bit timer.
REQ-033 SHALL implement the FIFO inline as a register array with wrap-around read and write pointers.

Verification (CLK_DIV=4, DATA_BITS=8, FIFO_DEPTH=4)
REQ-034 SHALL verify: push 0xA5, no parity, one stop → txd = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles, 40 cycles total, then busy falls.
REQ-035 SHALL verify: push 0xA5 with parity_en=1 → parity bit is 0 with parity_odd=0 and 1 with parity_odd=1; the frame is 44 cycles.
REQ-036 SHALL verify: push 5 words back-to-back → tx_ready falls at count=4, the 5th word is accepted after the first pop, and 5 contiguous frames appear with no idle high between a stop bit and the next start bit.
REQ-037 SHALL verify: two_stop=1 with 0x00 → start bit plus 8 zeros (36 cycles low), then 8 cycles high before the next frame.
REQ-038 SHALL verify: assert rst at cycle 15 of a frame → txd=1 and fifo_count=0 the same cycle, with no residual frame after release.
REQ-039 SHALL verify: with count=1 mid-frame, a push coinciding with the pop at STOP→START leaves fifo_count=1.
